// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encoding for the UART command scheduler.
package uart_cmd_pkg;

    localparam logic [7:0] CH_A    = 8'h61;
    localparam logic [7:0] CH_N    = 8'h6E;
    localparam logic [7:0] CH_P    = 8'h70;
    localparam logic [7:0] CH_SEMI = 8'h3B;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GOT_CMD = 2'd1,
        EXEC    = 2'd2,
        RESP    = 2'd3
    } state_t;

    function automatic logic is_cmd_char(input logic [7:0] b);
        return (b == CH_A) || (b == CH_N) || (b == CH_P);
    endfunction

endpackage

// File: rtl/uart_cmd_sched_tick_gen.sv
// Free-running auto-advance timer: pulses tick on the last count of each period.
module tick_gen #(
    parameter int TICK_CYCLES = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Counter parks at zero while disabled so re-enabling starts a full period.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_sched.sv
// Parses "a;", "n;", "p;" from the UART byte stream, maintains a wrapping
// pointer with optional auto-advance, and answers each command with one byte.
module uart_cmd_sched
    import uart_cmd_pkg::*;
#(
    parameter int         DEPTH       = 8,
    parameter int         PTR_W       = 3,
    parameter int         TICK_CYCLES = 100000000,
    parameter logic [7:0] ACK_BYTE    = 8'h4B,
    parameter logic [7:0] ERR_BYTE    = 8'h3F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_vld,
    input  logic [7:0]       din_data,
    input  logic             tx_ready,
    output logic             tx_vld,
    output logic [7:0]       tx_data,
    output logic [PTR_W-1:0] ptr,
    output logic             auto_en,
    output logic             busy,
    output logic             cmd_err
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    state_t           state, state_nxt;
    logic [7:0]       cmd, cmd_nxt;
    logic [PTR_W-1:0] ptr_nxt;
    logic             auto_nxt;
    logic             tx_vld_nxt;
    logic [7:0]       tx_data_nxt;
    logic             cmd_err_nxt;
    logic             busy_nxt;
    logic             tick;
    logic             tick_clr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? PTR_LAST : p - PTR_W'(1);
    endfunction

    tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (auto_en),
        .clr (tick_clr),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cmd     <= '0;
            ptr     <= '0;
            auto_en <= 1'b0;
            tx_vld  <= 1'b0;
            tx_data <= '0;
            cmd_err <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cmd     <= cmd_nxt;
            ptr     <= ptr_nxt;
            auto_en <= auto_nxt;
            tx_vld  <= tx_vld_nxt;
            tx_data <= tx_data_nxt;
            cmd_err <= cmd_err_nxt;
            busy    <= busy_nxt;
        end
    end

    // An auto tick is applied first so that an EXEC of 'n'/'p' overrides it.
    always_comb begin
        state_nxt   = state;
        cmd_nxt     = cmd;
        ptr_nxt     = ptr;
        auto_nxt    = auto_en;
        tx_data_nxt = tx_data;
        cmd_err_nxt = 1'b0;
        tick_clr    = 1'b0;

        if (tick) begin
            ptr_nxt = ptr_inc(ptr);
        end

        case (state)
            IDLE: begin
                if (din_vld && is_cmd_char(din_data)) begin
                    cmd_nxt   = din_data;
                    state_nxt = GOT_CMD;
                end
            end
            GOT_CMD: begin
                if (din_vld) begin
                    if (din_data == CH_SEMI) begin
                        state_nxt = EXEC;
                    end else begin
                        state_nxt   = RESP;
                        tx_data_nxt = ERR_BYTE;
                        cmd_err_nxt = 1'b1;
                    end
                end
            end
            EXEC: begin
                state_nxt   = RESP;
                tx_data_nxt = ACK_BYTE;
                case (cmd)
                    CH_N: ptr_nxt = ptr_inc(ptr);
                    CH_P: ptr_nxt = ptr_dec(ptr);
                    CH_A: begin
                        auto_nxt = !auto_en;
                        tick_clr = 1'b1;
                    end
                    default: ;
                endcase
            end
            RESP: begin
                if (tx_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        tx_vld_nxt = (state_nxt == RESP);
        busy_nxt   = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_uart_cmd_sched.sv
// Self-checking bench for uart_cmd_sched: vector table, scoreboarded responses,
// and hand-written sequences for back-pressure, auto tick and reset corners.
module tb_uart_cmd_sched;

    logic       clk;
    logic       rst;
    logic       din_vld;
    logic [7:0] din_data;
    logic       tx_ready;
    logic       tx_vld;
    logic [7:0] tx_data;
    logic [2:0] ptr;
    logic       auto_en;
    logic       busy;
    logic       cmd_err;

    int checks;
    int failures;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        int         exp_ptr;
        logic [7:0] exp_resp;
    } vec_t;

    vec_t vecs[10];

    uart_cmd_sched #(
        .DEPTH      (8),
        .PTR_W      (3),
        .TICK_CYCLES(10),
        .ACK_BYTE   (8'h4B),
        .ERR_BYTE   (8'h3F)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .din_vld (din_vld),
        .din_data(din_data),
        .tx_ready(tx_ready),
        .tx_vld  (tx_vld),
        .tx_data (tx_data),
        .ptr     (ptr),
        .auto_en (auto_en),
        .busy    (busy),
        .cmd_err (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        din_vld  = 1'b1;
        din_data = b;
        step();
        din_vld  = 1'b0;
        din_data = 8'h00;
    endtask

    task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] resp);
        exp_q.push_back(resp);
        send_byte(b0);
        send_byte(b1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        checkOutput("idle_timeout", int'(busy), 0);
    endtask

    // Scoreboard: every accepted handshake must match the oldest expected byte.
    always @(negedge clk) begin
        if (rst && tx_vld && tx_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_resp: got %0h expected none at %0t", tx_data, $time);
            end else begin
                checkOutput("resp", int'(tx_data), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int p_before;
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        din_vld  = 1'b0;
        din_data = 8'h00;
        tx_ready = 1'b1;

        vecs[0] = '{8'h70, 8'h3B, 0, 8'h4B};
        vecs[1] = '{8'h70, 8'h3B, 7, 8'h4B};
        for (int i = 0; i < 8; i++) begin
            vecs[2 + i] = '{8'h6E, 8'h3B, i, 8'h4B};
        end

        $display("[TB] reset with bytes strobed");
        send_byte(8'h6E);
        send_byte(8'h3B);
        send_byte(8'h61);
        checkOutput("rst_ptr", int'(ptr), 0);
        checkOutput("rst_auto", int'(auto_en), 0);
        checkOutput("rst_tx_vld", int'(tx_vld), 0);
        checkOutput("rst_busy", int'(busy), 0);
        rst = 1'b1;
        step();

        applyStimulus(8'h6E, 8'h3B, 8'h4B);
        checkOutput("t1_exec_tx_vld", int'(tx_vld), 0);
        step();
        checkOutput("t1_ptr", int'(ptr), 1);
        checkOutput("t1_tx_vld", int'(tx_vld), 1);
        checkOutput("t1_tx_data", int'(tx_data), 8'h4B);
        step();
        checkOutput("t1_tx_vld_drop", int'(tx_vld), 0);
        checkOutput("t1_busy", int'(busy), 0);

        $display("[TB] vector table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].b0, vecs[i].b1, vecs[i].exp_resp);
            wait_idle(10);
            checkOutput($sformatf("vec%0d_ptr", i), int'(ptr), vecs[i].exp_ptr);
        end
        checkOutput("vec_q_empty", exp_q.size(), 0);

        $display("[TB] malformed and ignored bytes");
        exp_q.push_back(8'h3F);
        send_byte(8'h6E);
        send_byte(8'h78);
        checkOutput("err_pulse", int'(cmd_err), 1);
        checkOutput("err_tx_data", int'(tx_data), 8'h3F);
        step();
        checkOutput("err_pulse_end", int'(cmd_err), 0);
        checkOutput("err_ptr", int'(ptr), 7);
        checkOutput("err_busy", int'(busy), 0);
        send_byte(8'h7A);
        checkOutput("ign_z", int'(busy), 0);
        send_byte(8'h71);
        checkOutput("ign_q", int'(busy), 0);
        send_byte(8'h20);
        checkOutput("ign_sp", int'(busy), 0);
        step(); step(); step();
        checkOutput("ign_tx_vld", int'(tx_vld), 0);
        checkOutput("ign_q_empty", exp_q.size(), 0);

        $display("[TB] back-pressure");
        tx_ready = 1'b0;
        applyStimulus(8'h6E, 8'h3B, 8'h4B);
        step();
        for (int i = 0; i < 20; i++) begin
            send_byte((i % 2 == 0) ? 8'h6E : 8'h3B);
            checkOutput($sformatf("bp_hold%0d", i), int'({tx_vld, tx_data}), 'h14B);
        end
        checkOutput("bp_ptr", int'(ptr), 0);
        tx_ready = 1'b1;
        step();
        checkOutput("bp_idle", int'(busy), 0);
        checkOutput("bp_tx_vld", int'(tx_vld), 0);
        step(); step();
        checkOutput("bp_ptr_after", int'(ptr), 0);
        checkOutput("bp_q_empty", exp_q.size(), 0);

        $display("[TB] auto tick");
        applyStimulus(8'h61, 8'h3B, 8'h4B);
        step();
        checkOutput("auto_on", int'(auto_en), 1);
        checkOutput("auto_ptr0", int'(ptr), 0);
        for (int i = 0; i < 9; i++) step();
        checkOutput("auto_pre_tick", int'(ptr), 0);
        step();
        checkOutput("auto_tick1", int'(ptr), 1);
        for (int k = 2; k <= 8; k++) begin
            for (int i = 0; i < 10; i++) step();
            checkOutput($sformatf("auto_tick%0d", k), int'(ptr), k % 8);
        end
        for (int i = 0; i < 7; i++) step();
        exp_q.push_back(8'h4B);
        send_byte(8'h70);
        send_byte(8'h3B);
        step();
        checkOutput("collide_ptr", int'(ptr), 7);
        for (int i = 0; i < 9; i++) step();
        checkOutput("collide_pre_tick", int'(ptr), 7);
        step();
        checkOutput("collide_next_tick", int'(ptr), 0);
        applyStimulus(8'h61, 8'h3B, 8'h4B);
        step();
        checkOutput("auto_off", int'(auto_en), 0);
        p_before = int'(ptr);
        for (int i = 0; i < 30; i++) step();
        checkOutput("auto_frozen", int'(ptr), p_before);
        checkOutput("frozen_val", p_before, 0);

        $display("[TB] reset mid-command");
        applyStimulus(8'h6E, 8'h3B, 8'h4B);
        wait_idle(10);
        applyStimulus(8'h61, 8'h3B, 8'h4B);
        wait_idle(10);
        checkOutput("r6_auto", int'(auto_en), 1);
        send_byte(8'h6E);
        checkOutput("r6_got_cmd", int'(busy), 1);
        rst = 1'b0;
        step();
        checkOutput("r6a_busy", int'(busy), 0);
        checkOutput("r6a_tx_vld", int'(tx_vld), 0);
        checkOutput("r6a_ptr", int'(ptr), 0);
        checkOutput("r6a_auto", int'(auto_en), 0);
        rst = 1'b1;
        tx_ready = 1'b0;
        send_byte(8'h6E);
        send_byte(8'h3B);
        step();
        checkOutput("r6_resp_vld", int'(tx_vld), 1);
        checkOutput("r6_resp_ptr", int'(ptr), 1);
        rst = 1'b0;
        step();
        checkOutput("r6b_busy", int'(busy), 0);
        checkOutput("r6b_tx_vld", int'(tx_vld), 0);
        checkOutput("r6b_ptr", int'(ptr), 0);
        checkOutput("r6b_auto", int'(auto_en), 0);
        rst = 1'b1;
        tx_ready = 1'b1;
        step(); step(); step();
        checkOutput("r6_no_resp", int'(tx_vld), 0);
        checkOutput("final_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
